// File: rtl/fre_aqc_pkg.sv
// Frequency counter shared definitions: register map,
// control/status bit positions and measurement FSM states.
package fre_aqc_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_GATE   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_CONT  = 1;
  localparam int STAT_BUSY  = 0;
  localparam int STAT_DONE  = 1;

  localparam logic [31:0] GATE_RST = 32'd100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_LATCH
  } state_e;

endpackage

// File: rtl/fre_aqc_gate_counter.sv
// Synchronises sig_in and counts its rising edges over a
// programmable gate window, one-shot or back-to-back.
module fre_aqc_gate_counter
  import fre_aqc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_cont,
  input  logic [31:0] i_gate,
  input  logic        i_sig,
  output logic        o_busy,
  output logic        o_meas_done,
  output logic [31:0] o_count
);

  state_e      r_state;
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic        r_meas_done;
  logic [31:0] r_cyc;
  logic [31:0] r_edges;
  logic [31:0] r_count;

  logic        w_edge;
  logic [31:0] w_len;
  logic [31:0] w_edges_nx;

  assign w_edge = r_s2 & ~r_s3;
  assign w_len  = (i_gate == '0) ? 32'd1 : i_gate;
  // saturate rather than wrap on very fast inputs
  assign w_edges_nx = (w_edge && r_edges != '1) ?
                      r_edges + 32'd1 : r_edges;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_s1        <= 1'b0;
      r_s2        <= 1'b0;
      r_s3        <= 1'b0;
      r_meas_done <= 1'b0;
      r_cyc       <= '0;
      r_edges     <= '0;
      r_count     <= '0;
    end else begin
      r_s1        <= i_sig;
      r_s2        <= r_s1;
      r_s3        <= r_s2;
      r_meas_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_state <= ST_GATE;
            r_cyc   <= w_len;
            r_edges <= '0;
          end
        end
        ST_GATE: begin
          r_edges <= w_edges_nx;
          r_cyc   <= r_cyc - 32'd1;
          if (r_cyc == 32'd1) begin
            r_state     <= ST_LATCH;
            r_meas_done <= 1'b1;
          end
        end
        ST_LATCH: begin
          r_count <= r_edges;
          if (i_cont) begin
            r_state <= ST_GATE;
            r_cyc   <= w_len;
            r_edges <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_meas_done = r_meas_done;
  assign o_count     = r_count;

endmodule

// File: rtl/fre_aqc_axil_slave.sv
// AXI4-Lite front end of the frequency counter: register
// file, write/read channels and the gate counter instance.
module fre_aqc_axil_slave
  import fre_aqc_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            sig_in,
  output logic                            meas_done
);

  logic                          r_awready;
  logic                          r_bvalid;
  logic                          r_arready;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_gate;
  logic                          r_cont;
  logic                          r_done;

  logic                          w_wr_hs;
  logic                          w_rd_hs;
  logic [1:0]                    w_wsel;
  logic [1:0]                    w_rsel;
  logic                          w_start;
  logic                          w_count_rd;
  logic                          w_busy;
  logic                          w_meas_done;
  logic [31:0]                   w_count;
  logic [C_S_AXI_DATA_WIDTH-1:0] w_rmux;
  logic                          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign w_wsel  = S_AXI_AWADDR[3:2];
  assign w_rsel  = S_AXI_ARADDR[3:2];
  assign w_wr_hs = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
  assign w_rd_hs = r_arready & S_AXI_ARVALID;

  assign w_start = w_wr_hs && (w_wsel == REG_CTRL) &&
                   S_AXI_WSTRB[0] && S_AXI_WDATA[CTRL_START];
  assign w_count_rd = w_rd_hs && (w_rsel == REG_COUNT);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_awready <= 1'b0;
      r_bvalid  <= 1'b0;
      r_gate    <= GATE_RST;
      r_cont    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_awready <= ~r_awready & S_AXI_AWVALID &
                   S_AXI_WVALID & ~r_bvalid;
      if (w_wr_hs)
        r_bvalid <= 1'b1;
      else if (S_AXI_BREADY)
        r_bvalid <= 1'b0;
      if (w_wr_hs && w_wsel == REG_CTRL && S_AXI_WSTRB[0])
        r_cont <= S_AXI_WDATA[CTRL_CONT];
      if (w_wr_hs && w_wsel == REG_GATE)
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++)
          if (S_AXI_WSTRB[b])
            r_gate[8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      // a completing measurement wins over a same-cycle clear
      if (w_meas_done)
        r_done <= 1'b1;
      else if ((w_start && !w_busy) || w_count_rd)
        r_done <= 1'b0;
    end
  end

  always_comb begin
    w_rmux = '0;
    unique case (w_rsel)
      REG_CTRL:   w_rmux[CTRL_CONT] = r_cont;
      REG_GATE:   w_rmux = r_gate;
      REG_COUNT:  w_rmux = w_count;
      REG_STATUS: begin
        w_rmux[STAT_BUSY] = w_busy;
        w_rmux[STAT_DONE] = r_done;
      end
      default:    w_rmux = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_arready <= ~r_arready & S_AXI_ARVALID & ~r_rvalid;
      if (w_rd_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rmux;
      end else if (S_AXI_RREADY) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  fre_aqc_gate_counter u_gate (
    .clk         (ACLK),
    .rst_n       (ARESETN),
    .i_start     (w_start),
    .i_cont      (r_cont),
    .i_gate      (r_gate),
    .i_sig       (sig_in),
    .o_busy      (w_busy),
    .o_meas_done (w_meas_done),
    .o_count     (w_count)
  );

  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY  = r_awready;
  assign S_AXI_BVALID  = r_bvalid;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID  = r_rvalid;
  assign S_AXI_RDATA   = r_rdata;
  assign S_AXI_RRESP   = 2'b00;
  assign meas_done     = w_meas_done;

endmodule

// File: tb/tb_fre_aqc_axil_slave.sv
// Directed bench for the AXI-Lite frequency counter with a
// register-level reference model and a per-cycle R/B checker.
module tb_fre_aqc_axil_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic        sig_in = 1'b0;
  logic        meas_done;

  fre_aqc_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
    .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .sig_in(sig_in), .meas_done(meas_done)
  );

  localparam logic [1:0] A_CTRL = 2'd0, A_GATE = 2'd1;
  localparam logic [1:0] A_COUNT = 2'd2, A_STAT = 2'd3;
  localparam int SQ_PERIOD = 8;

  always #5 ACLK = ~ACLK;

  // square wave, period 8 clocks, edges away from ACLK edges
  logic sq_en = 1'b0;
  always #40 sig_in = sq_en ? ~sig_in : 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int md_cnt = 0;
  int wr_md = 0;
  int md_t[$];
  logic [31:0] exp_q[$];

  // reference register model
  logic [31:0] m_gate;
  logic [31:0] m_count;
  logic        m_cont;
  logic        m_done;
  logic        m_busy;

  task automatic model_reset();
    m_gate = 32'h05F5E100; m_count = 0;
    m_cont = 0; m_done = 0; m_busy = 0;
  endtask

  task automatic model_write(input logic [1:0] a,
                             input logic [31:0] d,
                             input logic [3:0] s);
    if (a == A_CTRL && s[0]) begin
      if (d[0] && !m_busy) begin m_done = 0; m_busy = 1; end
      m_cont = d[1];
    end
    if (a == A_GATE)
      for (int b = 0; b < 4; b++)
        if (s[b]) m_gate[8*b +: 8] = d[8*b +: 8];
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    case (a)
      A_CTRL:  v = {30'd0, m_cont, 1'b0};
      A_GATE:  v = m_gate;
      A_COUNT: begin v = m_count; m_done = 0; end
      default: v = {30'd0, m_done, m_busy};
    endcase
    return v;
  endfunction

  // a measurement just finished: count = edges inside the window
  task automatic model_meas_end();
    m_busy = 0; m_done = 1; m_count = m_gate / SQ_PERIOD;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  always @(posedge ACLK) cyc++;

  always @(negedge ACLK) begin
    #1;
    if (meas_done === 1'b1) begin md_cnt++; md_t.push_back(cyc); end
  end

  // channel checker: every R beat against the model queue
  always @(negedge ACLK) begin
    #2;
    if (ARESETN) begin
      if (S_AXI_BVALID) chk("bresp", {30'd0, S_AXI_BRESP}, 0);
      if (S_AXI_RVALID) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL r_unexpected act=%h exp=none", S_AXI_RDATA);
        end else begin
          if (S_AXI_RDATA !== exp_q[0] || S_AXI_RRESP !== 2'b00) begin
            bad++;
            $display("FAIL rdata act=%h/%b exp=%h/00",
                     S_AXI_RDATA, S_AXI_RRESP, exp_q[0]);
          end
          if (S_AXI_RREADY) exp_q.delete(0);
        end
      end
    end
  end

  task automatic axi_write(input logic [1:0] a,
                           input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    @(negedge ACLK);
    S_AXI_AWADDR = {a, 2'b00}; S_AXI_WDATA = d; S_AXI_WSTRB = s;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("aw_w_ready", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    model_write(a, d, s);
    @(negedge ACLK);
    wr_md = md_cnt;
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge ACLK); n++; end
    @(negedge ACLK);
    chk("bvalid_drop", S_AXI_BVALID, 0);
  endtask

  task automatic axi_read(input logic [1:0] a, output logic [31:0] d);
    int n;
    @(negedge ACLK);
    S_AXI_ARADDR = {a, 2'b00}; S_AXI_ARVALID = 1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("arready", S_AXI_ARREADY, 1);
    exp_q.push_back(model_read(a));
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(negedge ACLK); n++; end
    d = S_AXI_RDATA;
    @(negedge ACLK);
  endtask

  task automatic wait_md(input int target, input int lim);
    int n;
    n = 0;
    while (md_cnt < target && n < lim) begin @(negedge ACLK); n++; end
    chk("md_wait", md_cnt >= target, 1);
  endtask

  initial begin
    logic [31:0] d;
    int n, md0, mdr;
    logic seen;
    model_reset();

    repeat (3) @(negedge ACLK);
    chk("rst_outs", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                     S_AXI_ARREADY, S_AXI_RVALID, meas_done}, 0);
    chk("rst_rdata", S_AXI_RDATA, 0);
    ARESETN = 1;
    sq_en = 1;

    axi_read(A_CTRL, d);  chk("rst_ctrl", d, 32'h0);
    axi_read(A_GATE, d);  chk("rst_gate", d, 32'h05F5E100);
    axi_read(A_COUNT, d); chk("rst_count", d, 32'h0);
    axi_read(A_STAT, d);  chk("rst_stat", d, 32'h0);

    axi_write(A_GATE, 32'hAABBCCDD, 4'b0101);
    axi_read(A_GATE, d);  chk("strb_gate", d, 32'h05BBE1DD);

    // single-shot measurement
    axi_write(A_GATE, 32'd80, 4'hF);
    md0 = md_cnt;
    axi_write(A_CTRL, 32'h1, 4'hF);
    wait_md(md0 + 1, 300);
    repeat (20) @(negedge ACLK);
    chk("single_md", md_cnt - md0, 1);
    model_meas_end();
    axi_read(A_STAT, d);  chk("single_stat", d, 32'h2);
    axi_read(A_COUNT, d); chk("single_count", d, 32'd10);
    axi_read(A_CTRL, d);  chk("single_ctrl", d, 32'h0);
    axi_read(A_STAT, d);

    // write backpressure: second write presented during held B
    @(negedge ACLK);
    S_AXI_BREADY = 0;
    S_AXI_AWADDR = {A_GATE, 2'b00}; S_AXI_WDATA = 32'd16;
    S_AXI_WSTRB = 4'hF; S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
    n = 0;
    while (!S_AXI_AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("bp_aw", S_AXI_AWREADY, 1);
    model_write(A_GATE, 32'd16, 4'hF);
    @(negedge ACLK);
    for (int i = 0; i < 5; i++) begin
      chk("bp_bhold", {S_AXI_BVALID, S_AXI_AWREADY}, 2'b10);
      @(negedge ACLK);
    end
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
    @(negedge ACLK);
    chk("bp_bdone", S_AXI_BVALID, 0);

    // read backpressure: checker compares RDATA every held cycle
    S_AXI_RREADY = 0;
    S_AXI_ARADDR = {A_GATE, 2'b00}; S_AXI_ARVALID = 1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("bp_ar", S_AXI_ARREADY, 1);
    exp_q.push_back(model_read(A_GATE));
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rhold", S_AXI_RVALID, 1);
      @(negedge ACLK);
    end
    S_AXI_RREADY = 1;
    @(negedge ACLK);
    chk("bp_rdone", S_AXI_RVALID, 0);

    // continuous mode, GATE = 16
    md0 = md_cnt;
    axi_write(A_CTRL, 32'h3, 4'hF);
    wait_md(md0 + 3, 300);
    axi_write(A_CTRL, 32'h3, 4'hF);
    wait_md(md0 + 6, 300);
    for (int i = md0; i < md0 + 5 && i + 1 < md_t.size(); i++)
      chk("cont_period", md_t[i+1] - md_t[i], m_gate + 1);
    axi_write(A_CTRL, 32'h0, 4'hF);
    mdr = wr_md;
    repeat (80) @(negedge ACLK);
    chk("cont_stop_md", md_cnt - mdr, 1);
    model_meas_end();
    axi_read(A_STAT, d);  chk("cont_stat", d, 32'h2);
    axi_read(A_COUNT, d); chk("cont_count", d, 32'd2);

    // reset in the middle of a gate with a read response pending
    axi_write(A_GATE, 32'd80, 4'hF);
    axi_write(A_CTRL, 32'h1, 4'hF);
    repeat (10) @(negedge ACLK);
    S_AXI_RREADY = 0;
    S_AXI_ARADDR = {A_STAT, 2'b00}; S_AXI_ARVALID = 1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("mid_ar", S_AXI_ARREADY, 1);
    exp_q.push_back(model_read(A_STAT));
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    repeat (2) @(negedge ACLK);
    ARESETN = 0;
    exp_q.delete();
    model_reset();
    mdr = md_cnt;
    repeat (2) @(negedge ACLK);
    chk("mid_rst_outs", {S_AXI_BVALID, S_AXI_RVALID, meas_done}, 0);
    ARESETN = 1;
    S_AXI_RREADY = 1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge ACLK);
      if (S_AXI_BVALID || S_AXI_RVALID) seen = 1;
    end
    chk("mid_no_resp", seen, 0);
    chk("mid_no_md", md_cnt - mdr, 0);
    axi_read(A_STAT, d);  chk("mid_stat", d, 32'h0);
    axi_read(A_COUNT, d); chk("mid_count", d, 32'h0);
    axi_read(A_GATE, d);  chk("mid_gate", d, 32'h05F5E100);

    repeat (5) @(negedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fre_aqc_axil_slave.md
FRE_AQC_AXIL_SLAVE -- requirements
Module: fre_aqc_axil_slave

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width for four 32-bit registers.
REQ-003 SHALL have one clock and an asynchronous active-low reset. Ports: ACLK input 1, sole clock; ARESETN input 1, asynchronous active-low reset.
REQ-004 Write address ports: S_AXI_AWADDR in 4; S_AXI_AWPROT in 3, ignored; S_AXI_AWVALID in 1; S_AXI_AWREADY out 1.
REQ-005 Write data ports: S_AXI_WDATA in 32; S_AXI_WSTRB in 4; S_AXI_WVALID in 1; S_AXI_WREADY out 1.
REQ-006 Write response ports: S_AXI_BRESP out 2; S_AXI_BVALID out 1; S_AXI_BREADY in 1.
REQ-007 Read address ports: S_AXI_ARADDR in 4; S_AXI_ARPROT in 3, ignored; S_AXI_ARVALID in 1; S_AXI_ARREADY out 1.
REQ-008 Read data ports: S_AXI_RDATA out 32; S_AXI_RRESP out 2; S_AXI_RVALID out 1; S_AXI_RREADY in 1.
REQ-009 Measurement ports: sig_in in 1, asynchronous signal under measurement; meas_done out 1, one-cycle pulse per completed measurement.

Function
REQ-010 Register map, decoded from address bits [3:2]:
- 0x0 CTRL, RW: bit0 START, write-1 pulse, reads 0; bit1 CONT, continuous mode.
- 0x4 GATE, RW: gate length in ACLK cycles.
- 0x8 COUNT, RO: last completed edge count.
- 0xC STATUS, RO: bit0 BUSY; bit1 DONE.
REQ-011 Write acceptance: only when AWVALID and WVALID are both high and BVALID is low; AWREADY and WREADY pulse high together for exactly that one cycle.
REQ-012 BVALID rises the cycle after acceptance and holds until BREADY is high; BRESP is always 2'b00.
REQ-013 Write data is applied per byte lane under WSTRB; writes to COUNT/STATUS complete with OKAY and change nothing.
REQ-014 Read acceptance: ARREADY pulses one cycle when ARVALID is high and RVALID is low.
REQ-015 RDATA is registered, RVALID rises the next cycle and holds with RDATA stable until RREADY; RRESP is always 2'b00.
REQ-016 Reads and writes proceed independently in the same cycle.
REQ-017 sig_in passes through a 2-FF synchronizer plus one delay register; edge = sync2 & ~sync3.
REQ-018 FSM states:
- IDLE: START written -> GATE next cycle.
- GATE: loads cycle counter = max(GATE,1) and clears edge counter on entry; counts edges for exactly that many cycles -> LATCH.
- LATCH, one cycle: COUNT <= edge count, DONE <= 1, meas_done = 1; then GATE if CONT = 1, else IDLE.
REQ-019 BUSY is 1 in GATE and LATCH.
REQ-020 START written while BUSY is ignored.
REQ-021 GATE written while BUSY takes effect at the next GATE entry.
REQ-022 The edge counter is 32-bit and saturates at 0xFFFFFFFF.
REQ-023 DONE clears when START is accepted or COUNT is read; a read of COUNT coincident with LATCH leaves DONE = 1.
REQ-024 Clearing CONT during GATE finishes the current measurement, then returns to IDLE.

Reset
REQ-025 ARESETN low asynchronously forces:
- all READY/VALID outputs 0; RDATA 0; meas_done 0
- CTRL 0; GATE 32'd100_000_000; COUNT 0; STATUS 0
- FSM IDLE; synchronizer and counters 0
REQ-026 Reset mid-transaction or mid-measurement discards the transaction and measurement; after release, no B or R response is issued for the discarded transaction.

Structure
REQ-027 Package fre_aqc_pkg SHALL hold the register offsets, CTRL/STATUS bit indices, GATE reset value, and FSM state enum.
REQ-028 The gate/edge counting logic SHALL be one sub-module, fre_aqc_gate_counter; AXI decode and registers stay in the top.

Verification
REQ-029 Reset check: after reset, read all four registers -> 0x0, 0x05F5E100, 0x0, 0x0 with RRESP OKAY.
REQ-030 Single measurement: write GATE = 80; sig_in square wave, period 8 cycles; write CTRL = 0x1 -> one meas_done pulse, COUNT = 10, STATUS = 0x2, CTRL reads 0x0.
REQ-031 Handshake backpressure: BREADY held low 5 cycles after a write -> BVALID held, no second AWREADY until B completes. RREADY low 5 cycles -> RDATA stable.
REQ-032 Byte strobes: write GATE = 0xAABBCCDD with WSTRB = 4'b0101 over 0x05F5E100 -> GATE reads 0x05BBE1DD.
REQ-033 Continuous mode and overlap:
- CTRL = 0x3, GATE = 16 -> meas_done every 17 cycles.
- START rewritten while BUSY -> no period change.
- CTRL = 0x0 written -> exactly one more meas_done.
REQ-034 Reset mid-GATE: drop ARESETN for 2 cycles during GATE -> BUSY = 0, COUNT = 0, no meas_done, BVALID/RVALID low.
